// File: rtl/dmem_initiator.sv
// Data-memory initiator: converts load/store requests to word-port accesses, tracks loads, aligns returns.
// Optional feature: define DMEM_ALIGN_CHECK_EN to drop misaligned accesses and pulse misalign.
module dmem_initiator #(
  parameter int READ_LAT = 3,
  parameter int HAZ_WIN  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        interlock,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [4:0]  req_rt,
  output logic        memory_used,
  output logic [31:0] addra,
  output logic [63:0] dina,
  output logic [7:0]  wea,
  output logic [31:0] addrb,
  input  logic [63:0] mem_doutb,
  output logic        ld_valid,
  output logic [63:0] ld_data,
  output logic [4:0]  ld_rt,
  output logic        hazard_stall,
  output logic        misalign
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rt;
    logic [1:0] size;
    logic       sgn;
    logic [2:0] lane;
  } trk_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] waddr;
  } hist_t;

  // trk[0] lines up with addrb, trk[READ_LAT] lines up with the returning mem_doutb.
  trk_t  trk  [READ_LAT+1];
  hist_t hist [HAZ_WIN];

  logic [31:0] req_waddr;
  logic [2:0]  size_mask;
  logic [7:0]  size_bytes;
  logic [2:0]  req_lane;
  logic        req_misalign;
  logic        hist_hit;
  logic        accept;
  logic        do_access;

  // NOTE: every always_comb output is given a default before any branch, so no latch is inferred.
  always_comb begin
    req_waddr  = {3'b000, req_addr[31:3]};
    size_mask  = 3'd7;
    size_bytes = 8'hff;
    case (req_size)
      2'd0: begin size_mask = 3'd0; size_bytes = 8'h01; end
      2'd1: begin size_mask = 3'd1; size_bytes = 8'h03; end
      2'd2: begin size_mask = 3'd3; size_bytes = 8'h0f; end
      2'd3: begin size_mask = 3'd7; size_bytes = 8'hff; end
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    req_misalign = |(req_addr[2:0] & size_mask);
    req_lane     = req_addr[2:0];
`else
    req_misalign = 1'b0;
    req_lane     = req_addr[2:0] & ~size_mask;
`endif
    hist_hit = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++)
      if (hist[i].valid && hist[i].waddr == req_waddr) hist_hit = 1'b1;
  end

  assign hazard_stall = req_valid & ~req_we & hist_hit;
  assign req_ready    = ~interlock & ~hazard_stall;
  assign accept       = req_valid & req_ready;
  assign do_access    = accept & ~req_misalign;

  function automatic logic [63:0] align_load(input logic [63:0] word, input trk_t t);
    logic [63:0] sh;
    sh = word >> {t.lane, 3'b000};
    case (t.size)
      2'd0:    align_load = t.sgn ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
      2'd1:    align_load = t.sgn ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
      2'd2:    align_load = t.sgn ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
      default: align_load = sh;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      memory_used <= 1'b0;
      addra       <= '0;
      dina        <= '0;
      wea         <= '0;
      addrb       <= '0;
      ld_valid    <= 1'b0;
      ld_data     <= '0;
      ld_rt       <= '0;
      misalign    <= 1'b0;
      // NOTE: these small flop arrays are cleared on reset so in-flight loads and stale stores are discarded.
      for (int i = 0; i <= READ_LAT; i++) trk[i] <= '0;
      for (int i = 0; i < HAZ_WIN; i++) hist[i] <= '0;
    end else begin
      memory_used <= 1'b0;
      wea         <= '0;
      ld_valid    <= 1'b0;
      misalign    <= 1'b0;
      if (!interlock) begin
        hist[0].valid <= do_access & req_we;
        hist[0].waddr <= req_waddr;
        for (int i = 1; i < HAZ_WIN; i++) hist[i] <= hist[i-1];

        trk[0].valid <= do_access & ~req_we;
        trk[0].rt    <= req_rt;
        trk[0].size  <= req_size;
        trk[0].sgn   <= req_signed;
        trk[0].lane  <= req_lane;
        for (int i = 1; i <= READ_LAT; i++) trk[i] <= trk[i-1];

        if (trk[READ_LAT].valid) begin
          ld_valid <= 1'b1;
          ld_data  <= align_load(mem_doutb, trk[READ_LAT]);
          ld_rt    <= trk[READ_LAT].rt;
        end

        misalign <= accept & req_misalign;
        if (do_access) begin
          memory_used <= 1'b1;
          if (req_we) begin
            addra <= req_waddr;
            dina  <= req_wdata << {req_lane, 3'b000};
            wea   <= size_bytes << req_lane;
          end else begin
            addrb <= req_waddr;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_initiator.sv
// Bench for dmem_initiator: directed scenarios plus random traffic checked against a byte-level
// memory model with load latency counted in non-interlocked cycles.
module tb_dmem_initiator;
  localparam int READ_LAT = 3;
  localparam int HAZ_WIN  = 2;
  localparam int NWORDS   = 16;

  logic        clk = 1'b0;
  logic        rstn, interlock, req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rt;
  logic        memory_used;
  logic [31:0] addra, addrb;
  logic [63:0] dina, mem_doutb, ld_data;
  logic [7:0]  wea;
  logic        ld_valid, hazard_stall, misalign;
  logic [4:0]  ld_rt;

  always #5 clk = ~clk;

  dmem_initiator #(.READ_LAT(READ_LAT), .HAZ_WIN(HAZ_WIN)) dut (
    .clk(clk), .rstn(rstn), .interlock(interlock), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rt(req_rt), .memory_used(memory_used), .addra(addra), .dina(dina),
    .wea(wea), .addrb(addrb), .mem_doutb(mem_doutb), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_rt(ld_rt), .hazard_stall(hazard_stall), .misalign(misalign)
  );

  function automatic logic [63:0] init_word(input int w);
    return 64'h0123_4567_89ab_cdef ^ (64'(w) * 64'h9e37_79b9_7f4a_7c15);
  endfunction

  // Memory stage: byte-enabled writes, READ_LAT-deep read pipe that stalls with the pipeline.
  logic [63:0] tb_mem  [NWORDS];
  logic [63:0] rd_pipe [READ_LAT];
  bit          mem_loaded;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int w = 0; w < NWORDS; w++) tb_mem[w] <= init_word(w);
      mem_loaded <= 1'b1;
    end else begin
      for (int b = 0; b < 8; b++)
        if (wea[b] === 1'b1) tb_mem[addra[3:0]][8*b +: 8] <= dina[8*b +: 8];
    end
    if (interlock !== 1'b1) begin
      rd_pipe[0] <= tb_mem[addrb[3:0]];
      for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign mem_doutb = rd_pipe[READ_LAT-1];

  // Reference model state.
  typedef struct {
    int          due;
    logic [4:0]  rt;
    logic [63:0] data;
  } pend_t;

  logic [7:0]  shadow [NWORDS*8];
  int          store_at [NWORDS];
  int          ni_cnt;
  pend_t       pend [$];
  logic        known, rst_seen;
  logic [7:0]  e_wea;
  logic        e_mu, e_ldv, e_mis;
  logic [63:0] e_ldd, e_dina;
  logic [31:0] e_addra, e_addrb;
  logic [4:0]  e_ldrt;

  // Observation bookkeeping for the directed scenarios.
  logic        last_acc;
  int          cyc, ld_cnt, mis_cnt, haz_cnt, last_ld_cyc, acc_cyc;
  logic [63:0] ld_last_data;
  logic [4:0]  rt_seen [$];

  int total, bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_haz(input logic v, input logic we, input logic [31:0] a);
    return v && !we && ((ni_cnt - store_at[int'(a[6:3])]) <= HAZ_WIN);
  endfunction

  function automatic logic [63:0] model_load(input int ea, input int nbytes, input logic sg);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < nbytes; i++) v[8*i +: 8] = shadow[ea+i];
    if (sg && v[8*nbytes-1])
      for (int i = 8*nbytes; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  // One clock cycle: drive, check combinational outputs, advance model at the edge, check registers.
  task automatic cycle(input logic rn, input logic il, input logic v, input logic we,
                       input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [63:0] wd, input logic [4:0] rt);
    logic  haz, acc, aligned;
    int    nbytes, w, ea, lane;
    pend_t p;
    rstn = rn; interlock = il; req_valid = v; req_we = we; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd; req_rt = rt;
    #1;
    haz = model_haz(v, we, a);
    if (known) begin
      check("hazard_stall", 64'(hazard_stall), 64'(haz));
      check("req_ready", 64'(req_ready), 64'(!il && !haz));
    end
    if (hazard_stall === 1'b1) haz_cnt++;
    @(posedge clk);
    cyc++;
    nbytes  = 1 << sz;
    aligned = (int'(a) % nbytes) == 0;
    acc     = rn && v && !il && !haz;
    e_wea = '0; e_mu = 1'b0; e_ldv = 1'b0; e_mis = 1'b0; rst_seen = 1'b0;
    if (!rn) begin
      pend.delete();
      foreach (store_at[i]) store_at[i] = -1000;
      e_addra = '0; e_addrb = '0; e_dina = '0; e_ldd = '0; e_ldrt = '0;
      known = 1'b1; rst_seen = 1'b1; acc = 1'b0;
    end else if (!il) begin
      if (pend.size() > 0 && pend[0].due == ni_cnt) begin
        e_ldv = 1'b1; e_ldd = pend[0].data; e_ldrt = pend[0].rt;
        void'(pend.pop_front());
      end
      if (acc) begin
`ifdef DMEM_ALIGN_CHECK_EN
        ea = int'(a);
        if (!aligned) e_mis = 1'b1;
`else
        ea = int'(a) - (int'(a) % nbytes);
        aligned = 1'b1;
`endif
        if (aligned) begin
          w = ea / 8; lane = ea % 8; e_mu = 1'b1;
          if (we) begin
            e_addra = 32'(w);
            e_dina  = wd << (8*lane);
            for (int i = 0; i < nbytes; i++) begin
              e_wea[lane+i] = 1'b1;
              shadow[ea+i]  = wd[8*i +: 8];
            end
            store_at[w] = ni_cnt;
          end else begin
            e_addrb = 32'(w);
            p.due = ni_cnt + READ_LAT + 1; p.rt = rt; p.data = model_load(ea, nbytes, sg);
            pend.push_back(p);
          end
        end
      end
      ni_cnt++;
    end
    last_acc = acc;
    @(negedge clk);
    if (known) begin
      check("memory_used", 64'(memory_used), 64'(e_mu));
      check("wea", 64'(wea), 64'(e_wea));
      check("ld_valid", 64'(ld_valid), 64'(e_ldv));
      check("misalign", 64'(misalign), 64'(e_mis));
      if (e_mu || rst_seen) check("addrb", 64'(addrb), 64'(e_addrb));
      if (e_wea != 0 || rst_seen) begin
        check("addra", 64'(addra), 64'(e_addra));
        check("dina", dina, e_dina);
      end
      if (e_ldv || rst_seen) begin
        check("ld_data", ld_data, e_ldd);
        check("ld_rt", 64'(ld_rt), 64'(e_ldrt));
      end
    end
    if (ld_valid === 1'b1) begin
      ld_cnt++; ld_last_data = ld_data; rt_seen.push_back(ld_rt); last_ld_cyc = cyc;
    end
    if (misalign === 1'b1) mis_cnt++;
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 64'h0, 5'd0);
  endtask

  task automatic load(input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [4:0] rt);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, sz, sg, a, 64'h0, rt);
  endtask

  initial begin
    logic [63:0] iw;
    logic        got;
    total = 0; bad = 0; known = 1'b0; ni_cnt = 0; cyc = 0;
    ld_cnt = 0; mis_cnt = 0; haz_cnt = 0; last_ld_cyc = 0; acc_cyc = 0;
    for (int w = 0; w < NWORDS; w++) begin
      iw = init_word(w);
      for (int b = 0; b < 8; b++) shadow[w*8+b] = iw[8*b +: 8];
    end
    foreach (store_at[i]) store_at[i] = -1000;

    // Reset held 3 cycles with a request present, then no stray load results.
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h8, 64'h0, 5'd7);
    check("rst_ld_data", ld_data, 64'h0);
    ld_cnt = 0;
    repeat (10) idle();
    check("rst_no_ld", 64'(ld_cnt), 64'd0);

    // Half store to 0x16 (lane 6), then a signed half load of the same bytes.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h16, 64'hbeef, 5'd0);
    check("sth_addra", 64'(addra), 64'h2);
    check("sth_wea", 64'(wea), 64'hc0);
    check("sth_dina", 64'(dina[63:48]), 64'hbeef);
    repeat (HAZ_WIN) idle();
    load(2'd1, 1'b1, 32'h16, 5'd3);
    ld_cnt = 0;
    repeat (3) idle();
    check("lh_not_early", 64'(ld_cnt), 64'd0);
    idle();
    check("lh_seen", 64'(ld_cnt), 64'd1);
    check("lh_data", ld_last_data, 64'hffff_ffff_ffff_beef);

    // Store dword to 0x40, then byte load from 0x41 held until accepted.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h40, 64'h1122_3344_5566_7788, 5'd0);
    haz_cnt = 0; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      load(2'd0, 1'b0, 32'h41, 5'd9);
      got = last_acc;
    end
    check("haz_accept", 64'(got), 64'd1);
    check("haz_cycles", 64'(haz_cnt), 64'(HAZ_WIN));
    check("haz_addrb", 64'(addrb), 64'h8);
    ld_cnt = 0;
    repeat (4) idle();
    check("haz_ld_seen", 64'(ld_cnt), 64'd1);
    check("haz_ld_data", ld_last_data, 64'h77);

    // Four back-to-back loads with a 2-cycle interlock in the middle.
    ld_cnt = 0; rt_seen.delete();
    load(2'd2, 1'b0, 32'h20, 5'd1);
    acc_cyc = cyc;
    load(2'd2, 1'b0, 32'h28, 5'd2);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 64'h0, 5'd3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 64'h0, 5'd3);
    load(2'd2, 1'b1, 32'h30, 5'd3);
    load(2'd3, 1'b0, 32'h38, 5'd4);
    repeat (8) idle();
    check("il_ld_count", 64'(ld_cnt), 64'd4);
    for (int i = 0; i < rt_seen.size() && i < 4; i++) check("il_rt_order", 64'(rt_seen[i]), 64'(i + 1));
    check("il_last_latency", 64'(last_ld_cyc - acc_cyc), 64'(READ_LAT + 1 + 3 + 2));

    // Reset while two loads are in flight, then a fresh load.
    load(2'd3, 1'b0, 32'h48, 5'd5);
    load(2'd3, 1'b0, 32'h50, 5'd6);
    idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 64'h0, 5'd0);
    ld_cnt = 0;
    repeat (8) idle();
    check("rst_discard", 64'(ld_cnt), 64'd0);
    load(2'd3, 1'b0, 32'h58, 5'd7);
    repeat (4) idle();
    check("post_rst_ld", 64'(ld_cnt), 64'd1);
    check("post_rst_rt", 64'(rt_seen[rt_seen.size()-1]), 64'd7);

    // Word load from 0x6.
    ld_cnt = 0; mis_cnt = 0;
    load(2'd2, 1'b0, 32'h6, 5'd11);
    repeat (4) idle();
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_pulse", 64'(mis_cnt), 64'd1);
    check("mis_no_ld", 64'(ld_cnt), 64'd0);
`else
    check("w6_no_mis", 64'(mis_cnt), 64'd0);
    check("w6_ld", 64'(ld_cnt), 64'd1);
    check("w6_data", ld_last_data, 64'h0123_4567);
`endif

    // Random traffic against the model.
    repeat (400)
      cycle(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 127)), {$urandom, $urandom}, 5'($urandom_range(0, 31)));
    repeat (8) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
